alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
Integer execute stage fed by the reservation station's issue port. It computes the RV32I integer, branch and jump result for each issued instruction and queues results in a small result FIFO. It broadcasts each result on the common data bus to the RS, LSB and ROB, one result per cycle, arbitrated by a bus-ready handshake. It gives the RS back-pressure through alu_full.

Parameters:
DATA_W, 32, operand/result width
ADDR_W, 32, pc width
ROB_W, 4, ROB rename tag width
OP_W, 6, decoded-op width (define.v op codes)
RES_DEPTH, 4, result FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
rdy  in  1  global ready; low = freeze
jump_wrong  in  1  misprediction flush
alu_enable  in  1  issue valid from RS
to_alu_op  in  OP_W  decoded op
to_alu_rs1_value  in  DATA_W  operand 1
to_alu_rs2_value  in  DATA_W  operand 2
to_alu_imm  in  DATA_W  immediate (sign-extended)
to_alu_pc  in  ADDR_W  instruction pc
to_alu_rd_renaming  in  ROB_W  destination ROB tag
alu_full  out  1  back-pressure to RS
cdb_ready  in  1  bus grant for ALU this cycle
alu_broadcast  out  1  result valid pulse
alu_cbd_value  out  DATA_W  result value
alu_update_rename  out  ROB_W  result ROB tag
alu_jump  out  1  branch/jump taken
alu_jump_target  out  ADDR_W  taken target pc

Behaviour:
- Reset (rst=0, async): FIFO empty; head, tail and count = 0. All outputs 0.
- Accept: when alu_enable=1, rdy=1 and jump_wrong=0, compute combinationally and write {value, tag, jump, target} at tail on that edge. Accept is unconditional; the RS honours alu_full.
- alu_full = (count >= RES_DEPTH-1), combinational from registered count. The one slot of slack covers the RS's registered issue. An alu_enable arriving with count==RES_DEPTH and no pop is dropped; that is a protocol error and the bench flags it.
- Pop/broadcast: on an edge with rdy=1, FIFO non-empty and cdb_ready=1, head moves to the output registers and alu_broadcast<=1. Otherwise alu_broadcast<=0. Value, tag, jump and target hold their last value.
- Latency: issue at edge N, broadcast visible after edge N+1, provided cdb_ready was 1.
- A push and a pop on the same edge leave count unchanged. Pointers wrap modulo RES_DEPTH.
- Arithmetic: op2 = rs2 for R-type and branches, imm for I-type.
  - ADD/ADDI, SUB: mod 2^32.
  - SLL/SRL/SRA(+I): shift amount = op2[4:0]; SRA sign-fills.
  - SLT/SLTU(+I): result 1 or 0, signed or unsigned compare.
  - AND/OR/XOR(+I).
  - LUI: value = imm. AUIPC: value = pc+imm.
- JAL: value = pc+4, jump=1, target = pc+imm.
- JALR: value = pc+4, jump=1, target = (rs1+imm) & ~1.
- BEQ/BNE/BLT/BGE/BLTU/BGEU: value = 0. jump = condition result. target = pc+imm when taken, pc+4 when not taken.
- jump_wrong=1 (rdy-independent): FIFO cleared, alu_broadcast<=0, same-cycle issue dropped.
- rdy=0: no push, no pop, alu_broadcast<=0, state held.
- Undefined op: value 0, jump 0, still broadcast so the ROB entry completes.

Optional Feature:
ALU_STAT_EN
- Defined: adds outputs stat_issued (32) and stat_taken (32).
  - stat_issued increments on each accepted issue.
  - stat_taken increments on each broadcast with jump=1.
  - Both clear on reset and saturate at 0xFFFFFFFF. jump_wrong does not clear them.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- ADD 5,7 tag 3, cdb_ready=1 -> one cycle after accept edge: alu_broadcast=1, value=12, tag=3, jump=0.
- SRA rs1=0x80000000, rs2=0x24 -> value=0xF8000000. SLTU 0xFFFFFFFF,1 -> 0. SLT 0xFFFFFFFF,1 -> 1.
- BNE pc=0x100, 1,2, imm=0x20 -> jump=1, target=0x120. BEQ with same operands -> jump=0, target=0x104. JALR rs1=0x205, imm=0 -> target=0x204, value=pc+4.
- cdb_ready=0, issue 3 ops (RES_DEPTH=4) -> alu_full=1 after the 3rd accept. Raise cdb_ready -> 3 consecutive broadcasts in issue order, then alu_full=0.
- 2 queued results, jump_wrong pulse -> alu_broadcast stays 0 afterwards, alu_full=0, count=0.
- Assert rst low mid-broadcast, asynchronously between clock edges -> outputs 0 immediately. After release, a fresh ADD broadcasts correctly.

Source files
------------

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Brief    : RV32I integer/branch/jump execute stage. Issued ops are computed
//            combinationally, queued in a small result FIFO and broadcast on
//            the common data bus one per cycle under a cdb_ready handshake.
//            Optional saturating issue/taken counters behind ALU_STAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int ROB_W     = 4,
    parameter int OP_W      = 6,
    parameter int RES_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              jump_wrong,
    input  logic              alu_enable,
    input  logic [OP_W-1:0]   to_alu_op,
    input  logic [DATA_W-1:0] to_alu_rs1_value,
    input  logic [DATA_W-1:0] to_alu_rs2_value,
    input  logic [DATA_W-1:0] to_alu_imm,
    input  logic [ADDR_W-1:0] to_alu_pc,
    input  logic [ROB_W-1:0]  to_alu_rd_renaming,
    output logic              alu_full,
    input  logic              cdb_ready,
    output logic              alu_broadcast,
    output logic [DATA_W-1:0] alu_cbd_value,
    output logic [ROB_W-1:0]  alu_update_rename,
    output logic              alu_jump,
    output logic [ADDR_W-1:0] alu_jump_target
`ifdef ALU_STAT_EN
    ,
    output logic [31:0]       stat_issued,
    output logic [31:0]       stat_taken
`endif
);

    localparam int c_PTR_W = $clog2(RES_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    // Decoded op codes shared with the issue logic
    localparam logic [OP_W-1:0] c_OP_LUI   = OP_W'(1);
    localparam logic [OP_W-1:0] c_OP_AUIPC = OP_W'(2);
    localparam logic [OP_W-1:0] c_OP_JAL   = OP_W'(3);
    localparam logic [OP_W-1:0] c_OP_JALR  = OP_W'(4);
    localparam logic [OP_W-1:0] c_OP_BEQ   = OP_W'(5);
    localparam logic [OP_W-1:0] c_OP_BNE   = OP_W'(6);
    localparam logic [OP_W-1:0] c_OP_BLT   = OP_W'(7);
    localparam logic [OP_W-1:0] c_OP_BGE   = OP_W'(8);
    localparam logic [OP_W-1:0] c_OP_BLTU  = OP_W'(9);
    localparam logic [OP_W-1:0] c_OP_BGEU  = OP_W'(10);
    localparam logic [OP_W-1:0] c_OP_ADDI  = OP_W'(11);
    localparam logic [OP_W-1:0] c_OP_SLTI  = OP_W'(12);
    localparam logic [OP_W-1:0] c_OP_SLTIU = OP_W'(13);
    localparam logic [OP_W-1:0] c_OP_XORI  = OP_W'(14);
    localparam logic [OP_W-1:0] c_OP_ORI   = OP_W'(15);
    localparam logic [OP_W-1:0] c_OP_ANDI  = OP_W'(16);
    localparam logic [OP_W-1:0] c_OP_SLLI  = OP_W'(17);
    localparam logic [OP_W-1:0] c_OP_SRLI  = OP_W'(18);
    localparam logic [OP_W-1:0] c_OP_SRAI  = OP_W'(19);
    localparam logic [OP_W-1:0] c_OP_ADD   = OP_W'(20);
    localparam logic [OP_W-1:0] c_OP_SUB   = OP_W'(21);
    localparam logic [OP_W-1:0] c_OP_SLL   = OP_W'(22);
    localparam logic [OP_W-1:0] c_OP_SLT   = OP_W'(23);
    localparam logic [OP_W-1:0] c_OP_SLTU  = OP_W'(24);
    localparam logic [OP_W-1:0] c_OP_XOR   = OP_W'(25);
    localparam logic [OP_W-1:0] c_OP_SRL   = OP_W'(26);
    localparam logic [OP_W-1:0] c_OP_SRA   = OP_W'(27);
    localparam logic [OP_W-1:0] c_OP_OR    = OP_W'(28);
    localparam logic [OP_W-1:0] c_OP_AND   = OP_W'(29);

    logic              w_use_imm;
    logic [DATA_W-1:0] w_op2;
    logic [4:0]        w_shamt;
    logic              w_eq;
    logic              w_lt_s;
    logic              w_lt_u;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_pc_plus_imm;
    logic [DATA_W-1:0] w_jalr_sum;
    logic [DATA_W-1:0] w_value;
    logic              w_jump;
    logic [ADDR_W-1:0] w_target;
    logic              w_push;
    logic              w_pop;

    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic [DATA_W-1:0]  r_val_mem [RES_DEPTH];
    logic [ROB_W-1:0]   r_tag_mem [RES_DEPTH];
    logic               r_jmp_mem [RES_DEPTH];
    logic [ADDR_W-1:0]  r_tgt_mem [RES_DEPTH];

    logic               r_broadcast;
    logic [DATA_W-1:0]  r_value;
    logic [ROB_W-1:0]   r_tag;
    logic               r_jump;
    logic [ADDR_W-1:0]  r_target;

    // I-type ALU ops take the immediate as second operand
    always_comb begin
        w_use_imm = 1'b0;
        case (to_alu_op)
            c_OP_ADDI, c_OP_SLTI, c_OP_SLTIU, c_OP_XORI, c_OP_ORI,
            c_OP_ANDI, c_OP_SLLI, c_OP_SRLI, c_OP_SRAI: w_use_imm = 1'b1;
            default: w_use_imm = 1'b0;
        endcase
    end

    assign w_op2         = w_use_imm ? to_alu_imm : to_alu_rs2_value;
    assign w_shamt       = w_op2[4:0];
    assign w_eq          = (to_alu_rs1_value == w_op2);
    assign w_lt_s        = ($signed(to_alu_rs1_value) < $signed(w_op2));
    assign w_lt_u        = (to_alu_rs1_value < w_op2);
    assign w_pc_plus4    = to_alu_pc + ADDR_W'(4);
    assign w_pc_plus_imm = to_alu_pc + ADDR_W'(to_alu_imm);
    assign w_jalr_sum    = to_alu_rs1_value + to_alu_imm;

    // Result, taken flag and target of the op currently on the issue port
    always_comb begin
        w_value  = '0;
        w_jump   = 1'b0;
        w_target = '0;
        case (to_alu_op)
            c_OP_ADD, c_OP_ADDI:   w_value = to_alu_rs1_value + w_op2;
            c_OP_SUB:              w_value = to_alu_rs1_value - w_op2;
            c_OP_SLL, c_OP_SLLI:   w_value = to_alu_rs1_value << w_shamt;
            c_OP_SRL, c_OP_SRLI:   w_value = to_alu_rs1_value >> w_shamt;
            c_OP_SRA, c_OP_SRAI:   w_value = $signed(to_alu_rs1_value) >>> w_shamt;
            c_OP_SLT, c_OP_SLTI:   w_value = {{(DATA_W-1){1'b0}}, w_lt_s};
            c_OP_SLTU, c_OP_SLTIU: w_value = {{(DATA_W-1){1'b0}}, w_lt_u};
            c_OP_AND, c_OP_ANDI:   w_value = to_alu_rs1_value & w_op2;
            c_OP_OR, c_OP_ORI:     w_value = to_alu_rs1_value | w_op2;
            c_OP_XOR, c_OP_XORI:   w_value = to_alu_rs1_value ^ w_op2;
            c_OP_LUI:              w_value = to_alu_imm;
            c_OP_AUIPC:            w_value = DATA_W'(w_pc_plus_imm);
            c_OP_JAL: begin
                w_value  = DATA_W'(w_pc_plus4);
                w_jump   = 1'b1;
                w_target = w_pc_plus_imm;
            end
            c_OP_JALR: begin
                w_value  = DATA_W'(w_pc_plus4);
                w_jump   = 1'b1;
                w_target = ADDR_W'(w_jalr_sum) & ~ADDR_W'(1);
            end
            c_OP_BEQ, c_OP_BNE, c_OP_BLT, c_OP_BGE, c_OP_BLTU, c_OP_BGEU: begin
                case (to_alu_op)
                    c_OP_BEQ:  w_jump = w_eq;
                    c_OP_BNE:  w_jump = ~w_eq;
                    c_OP_BLT:  w_jump = w_lt_s;
                    c_OP_BGE:  w_jump = ~w_lt_s;
                    c_OP_BLTU: w_jump = w_lt_u;
                    default:   w_jump = ~w_lt_u;
                endcase
                w_target = w_jump ? w_pc_plus_imm : w_pc_plus4;
            end
            default: ;
        endcase
    end

    // A pop frees the head slot, so a push into a full FIFO is still legal then
    assign w_pop    = rdy & ~jump_wrong & cdb_ready & (r_count != '0);
    assign w_push   = alu_enable & rdy & ~jump_wrong &
                      ((r_count != c_CNT_W'(RES_DEPTH)) | w_pop);
    assign alu_full = (r_count >= c_CNT_W'(RES_DEPTH - 1));

    // FIFO pointers and occupancy; a flush empties the queue outright
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (jump_wrong) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + c_PTR_W'(1);
            if (w_pop)  r_head <= r_head + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Result storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_val_mem[r_tail] <= w_value;
            r_tag_mem[r_tail] <= to_alu_rd_renaming;
            r_jmp_mem[r_tail] <= w_jump;
            r_tgt_mem[r_tail] <= w_target;
        end
    end

    // Bus output registers: payload holds, valid pulses once per pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_broadcast <= 1'b0;
            r_value     <= '0;
            r_tag       <= '0;
            r_jump      <= 1'b0;
            r_target    <= '0;
        end else begin
            r_broadcast <= w_pop;
            if (w_pop) begin
                r_value  <= r_val_mem[r_head];
                r_tag    <= r_tag_mem[r_head];
                r_jump   <= r_jmp_mem[r_head];
                r_target <= r_tgt_mem[r_head];
            end
        end
    end

    assign alu_broadcast     = r_broadcast;
    assign alu_cbd_value     = r_value;
    assign alu_update_rename = r_tag;
    assign alu_jump          = r_jump;
    assign alu_jump_target   = r_target;

`ifdef ALU_STAT_EN
    logic [31:0] r_stat_issued;
    logic [31:0] r_stat_taken;

    // Saturating activity counters, untouched by misprediction flushes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_issued <= '0;
            r_stat_taken  <= '0;
        end else begin
            if (w_push && (r_stat_issued != 32'hFFFF_FFFF))
                r_stat_issued <= r_stat_issued + 32'd1;
            if (w_pop && r_jmp_mem[r_head] && (r_stat_taken != 32'hFFFF_FFFF))
                r_stat_taken <= r_stat_taken + 32'd1;
        end
    end

    assign stat_issued = r_stat_issued;
    assign stat_taken  = r_stat_taken;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Brief    : Self-checking bench for alu_exec_unit: directed vector table,
//            FIFO full/flush/async-reset sequences and a randomized run
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    localparam logic [5:0] LUI = 1, AUIPC = 2, JAL = 3, JALR = 4, BEQ = 5, BNE = 6,
        BLT = 7, BGE = 8, BLTU = 9, BGEU = 10, ADDI = 11, SLTI = 12, SLTIU = 13,
        XORI = 14, ORI = 15, ANDI = 16, SLLI = 17, SRLI = 18, SRAI = 19, ADD = 20,
        SUB = 21, SLL = 22, SLT = 23, SLTU = 24, XOR = 25, SRL = 26, SRA = 27,
        OR = 28, AND = 29, UNDEF = 63;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        jump_wrong = 1'b0;
    logic        alu_enable = 1'b0;
    logic [5:0]  to_alu_op = '0;
    logic [31:0] to_alu_rs1_value = '0;
    logic [31:0] to_alu_rs2_value = '0;
    logic [31:0] to_alu_imm = '0;
    logic [31:0] to_alu_pc = '0;
    logic [3:0]  to_alu_rd_renaming = '0;
    logic        alu_full;
    logic        cdb_ready = 1'b0;
    logic        alu_broadcast;
    logic [31:0] alu_cbd_value;
    logic [3:0]  alu_update_rename;
    logic        alu_jump;
    logic [31:0] alu_jump_target;
`ifdef ALU_STAT_EN
    logic [31:0] stat_issued;
    logic [31:0] stat_taken;
`endif

    alu_exec_unit dut (
        .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
        .alu_enable(alu_enable), .to_alu_op(to_alu_op),
        .to_alu_rs1_value(to_alu_rs1_value), .to_alu_rs2_value(to_alu_rs2_value),
        .to_alu_imm(to_alu_imm), .to_alu_pc(to_alu_pc),
        .to_alu_rd_renaming(to_alu_rd_renaming), .alu_full(alu_full),
        .cdb_ready(cdb_ready), .alu_broadcast(alu_broadcast),
        .alu_cbd_value(alu_cbd_value), .alu_update_rename(alu_update_rename),
        .alu_jump(alu_jump), .alu_jump_target(alu_jump_target)
`ifdef ALU_STAT_EN
        , .stat_issued(stat_issued), .stat_taken(stat_taken)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] rs1, rs2, imm, pc;
        logic [3:0]  tag;
        logic [31:0] ev;
        logic        ej;
        logic [31:0] et;
        logic        ct;   // target is meaningful (branch/jump)
    } vec_t;

    typedef struct {
        logic [31:0] v;
        logic [3:0]  tag;
        logic        j;
        logic [31:0] t;
        logic        ct;
    } res_t;

    int   n_pass = 0;
    int   n_total = 0;
    vec_t vq[$];
    res_t model_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mk(input string n, input logic [5:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] imm,
                                input logic [31:0] pc, input logic [3:0] tag,
                                input logic [31:0] ev, input logic ej,
                                input logic [31:0] et, input logic ct);
        vec_t r;
        r.name = n; r.op = op; r.rs1 = a; r.rs2 = b; r.imm = imm; r.pc = pc;
        r.tag = tag; r.ev = ev; r.ej = ej; r.et = et; r.ct = ct;
        return r;
    endfunction

    // Architectural meaning of each op, straight from the ISA rules
    function automatic res_t ref_exec(input logic [5:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] imm,
                                      input logic [31:0] pc, input logic [3:0] tag);
        res_t r;
        int sa, sb, si;
        longint ua, ub, ui;
        bit take;
        sa = int'(a); sb = int'(b); si = int'(imm);
        ua = longint'({32'd0, a}); ub = longint'({32'd0, b}); ui = longint'({32'd0, imm});
        r.v = 0; r.j = 0; r.t = 0; r.ct = 0; r.tag = tag; take = 0;
        case (op)
            ADD:   r.v = a + b;
            ADDI:  r.v = a + imm;
            SUB:   r.v = a - b;
            SLL:   r.v = a << (b % 32);
            SLLI:  r.v = a << (imm % 32);
            SRL:   r.v = a >> (b % 32);
            SRLI:  r.v = a >> (imm % 32);
            SRA:   r.v = 32'(sa >>> (b % 32));
            SRAI:  r.v = 32'(sa >>> (imm % 32));
            SLT:   r.v = (sa < sb) ? 1 : 0;
            SLTI:  r.v = (sa < si) ? 1 : 0;
            SLTU:  r.v = (ua < ub) ? 1 : 0;
            SLTIU: r.v = (ua < ui) ? 1 : 0;
            AND:   r.v = a & b;
            ANDI:  r.v = a & imm;
            OR:    r.v = a | b;
            ORI:   r.v = a | imm;
            XOR:   r.v = a ^ b;
            XORI:  r.v = a ^ imm;
            LUI:   r.v = imm;
            AUIPC: r.v = pc + imm;
            JAL:   begin r.v = pc + 4; r.j = 1; r.t = pc + imm; r.ct = 1; end
            JALR:  begin r.v = pc + 4; r.j = 1; r.t = (a + imm) & 32'hFFFF_FFFE; r.ct = 1; end
            BEQ, BNE, BLT, BGE, BLTU, BGEU: begin
                case (op)
                    BEQ:     take = (a == b);
                    BNE:     take = (a != b);
                    BLT:     take = (sa < sb);
                    BGE:     take = (sa >= sb);
                    BLTU:    take = (ua < ub);
                    default: take = (ua >= ub);
                endcase
                r.j = take; r.t = take ? pc + imm : pc + 4; r.ct = 1;
            end
            default: ;
        endcase
        return r;
    endfunction

    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag);
        to_alu_op = op; to_alu_rs1_value = a; to_alu_rs2_value = b;
        to_alu_imm = imm; to_alu_pc = pc; to_alu_rd_renaming = tag;
    endtask

    // One-cycle issue; returns #1 after the accept edge
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag);
        drive(op, a, b, imm, pc, tag);
        alu_enable = 1'b1;
        @(posedge clk); #1;
        alu_enable = 1'b0;
    endtask

    logic [5:0] op_list [30] = '{LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI, ADD, SUB, SLL, SLT, SLTU,
        XOR, SRL, SRA, OR, AND, UNDEF};

    initial begin
        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_broadcast", 32'(alu_broadcast), 0);
        check("rst_value", alu_cbd_value, 0);
        check("rst_tag", 32'(alu_update_rename), 0);
        check("rst_jump", 32'(alu_jump), 0);
        check("rst_target", alu_jump_target, 0);
        check("rst_full", 32'(alu_full), 0);
        #3 rst = 1'b1;
        @(posedge clk); #1;

        // ---------------- directed vector table ----------------
        vq.push_back(mk("add",   ADD,   5, 7, 0, 0, 3, 12, 0, 0, 0));
        vq.push_back(mk("sra",   SRA,   32'h8000_0000, 32'h24, 0, 0, 1, 32'hF800_0000, 0, 0, 0));
        vq.push_back(mk("sltu",  SLTU,  32'hFFFF_FFFF, 1, 0, 0, 2, 0, 0, 0, 0));
        vq.push_back(mk("slt",   SLT,   32'hFFFF_FFFF, 1, 0, 0, 4, 1, 0, 0, 0));
        vq.push_back(mk("bne",   BNE,   1, 2, 32'h20, 32'h100, 5, 0, 1, 32'h120, 1));
        vq.push_back(mk("beq",   BEQ,   1, 2, 32'h20, 32'h100, 6, 0, 0, 32'h104, 1));
        vq.push_back(mk("jalr",  JALR,  32'h205, 0, 0, 32'h300, 7, 32'h304, 1, 32'h204, 1));
        vq.push_back(mk("jal",   JAL,   0, 0, 32'hFFFF_FFF0, 32'h1000, 8, 32'h1004, 1, 32'hFF0, 1));
        vq.push_back(mk("sub",   SUB,   3, 5, 0, 0, 9, 32'hFFFF_FFFE, 0, 0, 0));
        vq.push_back(mk("lui",   LUI,   0, 0, 32'h1234_5000, 0, 10, 32'h1234_5000, 0, 0, 0));
        vq.push_back(mk("auipc", AUIPC, 0, 0, 32'h1000, 32'h400, 11, 32'h1400, 0, 0, 0));
        vq.push_back(mk("slli",  SLLI,  1, 32'hDEAD, 31, 0, 12, 32'h8000_0000, 0, 0, 0));
        vq.push_back(mk("srli",  SRLI,  32'h8000_0000, 0, 4, 0, 13, 32'h0800_0000, 0, 0, 0));
        vq.push_back(mk("addi",  ADDI,  32'hFFFF_FFFF, 0, 1, 0, 14, 0, 0, 0, 0));
        vq.push_back(mk("xori",  XORI,  32'hF0F0_F0F0, 0, 32'hFFFF_FFFF, 0, 15, 32'h0F0F_0F0F, 0, 0, 0));
        vq.push_back(mk("andi",  ANDI,  32'h1234_5678, 0, 32'h0000_FF00, 0, 1, 32'h0000_5600, 0, 0, 0));
        vq.push_back(mk("ori",   ORI,   32'h1234_0000, 0, 32'h5678, 0, 2, 32'h1234_5678, 0, 0, 0));
        vq.push_back(mk("sltiu", SLTIU, 0, 0, 32'hFFFF_FFFF, 0, 3, 1, 0, 0, 0));
        vq.push_back(mk("srl",   SRL,   32'hFFFF_FFFF, 32'h21, 0, 0, 4, 32'h7FFF_FFFF, 0, 0, 0));
        vq.push_back(mk("sll",   SLL,   3, 4, 0, 0, 5, 32'h30, 0, 0, 0));
        vq.push_back(mk("blt",   BLT,   32'hFFFF_FFFF, 1, 32'h10, 32'h200, 6, 0, 1, 32'h210, 1));
        vq.push_back(mk("bltu",  BLTU,  32'hFFFF_FFFF, 1, 32'h10, 32'h200, 7, 0, 0, 32'h204, 1));
        vq.push_back(mk("bge",   BGE,   5, 5, 32'hFFFF_FFF8, 32'h200, 8, 0, 1, 32'h1F8, 1));
        vq.push_back(mk("bgeu",  BGEU,  0, 1, 32'h10, 32'h200, 9, 0, 0, 32'h204, 1));
        vq.push_back(mk("undef", UNDEF, 5, 6, 7, 32'h40, 10, 0, 0, 0, 0));

        cdb_ready = 1'b1;
        for (int i = 0; i < vq.size(); i++) begin
            issue(vq[i].op, vq[i].rs1, vq[i].rs2, vq[i].imm, vq[i].pc, vq[i].tag);
            @(posedge clk); #1;
            check({vq[i].name, "_bcast"}, 32'(alu_broadcast), 1);
            check({vq[i].name, "_value"}, alu_cbd_value, vq[i].ev);
            check({vq[i].name, "_tag"}, 32'(alu_update_rename), 32'(vq[i].tag));
            check({vq[i].name, "_jump"}, 32'(alu_jump), 32'(vq[i].ej));
            if (vq[i].ct) check({vq[i].name, "_target"}, alu_jump_target, vq[i].et);
        end
        @(posedge clk); #1;
        check("bcast_one_pulse", 32'(alu_broadcast), 0);

        // ---------------- flush with queued results ----------------
        cdb_ready = 1'b0;
        issue(ADD, 1, 1, 0, 0, 1);
        issue(ADD, 2, 2, 0, 0, 2);
        drive(ADD, 3, 3, 0, 0, 3);
        alu_enable = 1'b1; jump_wrong = 1'b1;
        @(posedge clk); #1;
        alu_enable = 1'b0; jump_wrong = 1'b0; cdb_ready = 1'b1;
        check("flush_full", 32'(alu_full), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("flush_no_bcast", 32'(alu_broadcast), 0);
        end

        // ---------------- fill to alu_full, then drain in order ----------------
        cdb_ready = 1'b0;
        issue(ADD, 10, 1, 0, 0, 4);
        check("fill1_full", 32'(alu_full), 0);
        issue(SUB, 10, 1, 0, 0, 5);
        check("fill2_full", 32'(alu_full), 0);
        issue(XOR, 10, 1, 0, 0, 6);
        check("fill3_full", 32'(alu_full), 1);
        cdb_ready = 1'b1;
        @(posedge clk); #1;
        check("drain1_bcast", 32'(alu_broadcast), 1);
        check("drain1_tag", 32'(alu_update_rename), 4);
        check("drain1_value", alu_cbd_value, 11);
        @(posedge clk); #1;
        check("drain2_bcast", 32'(alu_broadcast), 1);
        check("drain2_tag", 32'(alu_update_rename), 5);
        check("drain2_value", alu_cbd_value, 9);
        @(posedge clk); #1;
        check("drain3_bcast", 32'(alu_broadcast), 1);
        check("drain3_tag", 32'(alu_update_rename), 6);
        check("drain3_value", alu_cbd_value, 11);
        check("drain_full", 32'(alu_full), 0);
        @(posedge clk); #1;
        check("drain_idle", 32'(alu_broadcast), 0);

        // ---------------- randomized run against the queue model ----------------
        model_q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic [31:0] a, b, imm, pc;
            logic [5:0]  op;
            logic [3:0]  tag;
            res_t        exp_r;
            bit          exp_pop;
            rdy        = ($urandom_range(0, 9) != 0);
            cdb_ready  = ($urandom_range(0, 3) != 0);
            jump_wrong = ($urandom_range(0, 39) == 0);
            alu_enable = !alu_full && ($urandom_range(0, 2) != 0);
            op  = op_list[$urandom_range(0, 29)];
            a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            imm = $urandom;
            pc  = {$urandom, 2'b00} & 32'h000F_FFFC;
            tag = 4'($urandom);
            drive(op, a, b, imm, pc, tag);
            exp_pop = 0;
            exp_r   = '{v: 0, tag: 0, j: 0, t: 0, ct: 0};
            if (jump_wrong) model_q.delete();
            else if (rdy) begin
                if (model_q.size() > 0 && cdb_ready) begin
                    exp_r = model_q.pop_front();
                    exp_pop = 1;
                end
                if (alu_enable) model_q.push_back(ref_exec(op, a, b, imm, pc, tag));
            end
            @(posedge clk); #1;
            check("rnd_bcast", 32'(alu_broadcast), 32'(exp_pop));
            if (exp_pop) begin
                check("rnd_value", alu_cbd_value, exp_r.v);
                check("rnd_tag", 32'(alu_update_rename), 32'(exp_r.tag));
                check("rnd_jump", 32'(alu_jump), 32'(exp_r.j));
                if (exp_r.ct) check("rnd_target", alu_jump_target, exp_r.t);
            end
            check("rnd_full", 32'(alu_full), (model_q.size() >= 3) ? 1 : 0);
        end
        alu_enable = 1'b0; rdy = 1'b1; jump_wrong = 1'b1;
        @(posedge clk); #1;
        jump_wrong = 1'b0;

        // ---------------- async reset mid-broadcast ----------------
        cdb_ready = 1'b0;
        issue(ADD, 1, 1, 0, 0, 1);
        issue(ADD, 2, 2, 0, 0, 2);
        cdb_ready = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_bcast", 32'(alu_broadcast), 1);
        check("pre_rst_value", alu_cbd_value, 2);
        #2 rst = 1'b0;
        #1;
        check("arst_bcast", 32'(alu_broadcast), 0);
        check("arst_value", alu_cbd_value, 0);
        check("arst_tag", 32'(alu_update_rename), 0);
        check("arst_jump", 32'(alu_jump), 0);
        check("arst_target", alu_jump_target, 0);
        check("arst_full", 32'(alu_full), 0);
        #2 rst = 1'b1;
        issue(ADD, 10, 20, 0, 0, 7);
        @(posedge clk); #1;
        check("post_rst_bcast", 32'(alu_broadcast), 1);
        check("post_rst_value", alu_cbd_value, 30);
        check("post_rst_tag", 32'(alu_update_rename), 7);
        check("post_rst_jump", 32'(alu_jump), 0);
        @(posedge clk); #1;
        check("post_rst_empty", 32'(alu_broadcast), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
